bmp_stream_packer: RTL and testbench

Output-side packer for the edge-detect pipeline: pops grayscale results from the `edge_detect_top` output FIFO and emits a complete 24-bit BMP file as a byte stream with valid/ready handshake. It generates the 54-byte header from parameters, then expands each gray sample to three equal B,G,R bytes, and zero-pads rows to 4-byte multiples. Pixel order is input order; the block does no reordering.

---
 rtl/bmp_stream_packer.sv | 175 +++++++++++++++++
 tb/tb_bmp_stream_packer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmp_stream_packer.sv
// Streams a complete 24-bit BMP file: a 54-byte header, then each gray sample
// expanded to equal B,G,R bytes, with each row zero-padded to a 4-byte multiple.
module bmp_stream_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_empty,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_rd,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int          PAD       = (4 - ((3 * IMG_WIDTH) % 4)) % 4;
  localparam logic        HAS_PAD   = (PAD != 0);
  localparam logic [31:0] IMG_SZ    = 32'(IMG_HEIGHT) * 32'(3 * IMG_WIDTH + PAD);
  localparam logic [31:0] FILE_SZ   = 32'd54 + IMG_SZ;
  localparam logic [15:0] COL_LAST  = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] ROW_LAST  = 16'(IMG_HEIGHT - 1);
  localparam logic [1:0]  PAD_LAST  = 2'(PAD - 1);

  // Header laid out so that file byte i sits at bits [8*i +: 8].
  localparam logic [431:0] HDR = {
    64'd0, 32'd2835, 32'd2835, IMG_SZ, 32'd0, 16'd24, 16'd1,
    32'(IMG_HEIGHT), 32'(IMG_WIDTH), 32'd40, 32'd54, 32'd0, FILE_SZ, 16'h4D42
  };

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PIXEL, S_PAD, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  hdr_idx_q, hdr_idx_d;
  logic [1:0]  sub_q, sub_d;
  logic [1:0]  pad_q, pad_d;
  logic [15:0] col_q, col_d;
  logic [15:0] row_q, row_d;

  logic       hs;
  logic       pix_end;
  logic       row_end;
  logic       pad_end;
  logic [8:0] bit_idx;

  assign bit_idx = {hdr_idx_q, 3'b000};
  assign pix_end = (sub_q == 2'd2) && (col_q == COL_LAST);
  assign row_end = (row_q == ROW_LAST);
  assign pad_end = (pad_q == PAD_LAST);

  // All outputs decode from registered state; only FIFO status/data pass through.
  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    in_rd     = 1'b0;
    case (state_q)
      S_HEADER: begin
        out_valid = 1'b1;
        out_data  = HDR[bit_idx +: 8];
      end
      S_PIXEL: begin
        out_valid = !in_empty;
        out_data  = in_data[DATA_WIDTH-1 -: 8];
        out_last  = !HAS_PAD && pix_end && row_end && !in_empty;
        in_rd     = (sub_q == 2'd2) && !in_empty && out_ready;
      end
      S_PAD: begin
        out_valid = 1'b1;
        out_last  = pad_end && row_end;
      end
      default: ;
    endcase
  end

  assign hs   = out_valid && out_ready;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

  always_comb begin
    state_d   = state_q;
    hdr_idx_d = hdr_idx_q;
    sub_d     = sub_q;
    pad_d     = pad_q;
    col_d     = col_q;
    row_d     = row_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_HEADER;
          hdr_idx_d = 6'd0;
        end
      end
      S_HEADER: begin
        if (hs) begin
          if (hdr_idx_q == 6'd53) begin
            state_d = S_PIXEL;
            sub_d   = 2'd0;
            col_d   = 16'd0;
            row_d   = 16'd0;
          end else begin
            hdr_idx_d = hdr_idx_q + 6'd1;
          end
        end
      end
      S_PIXEL: begin
        if (hs) begin
          if (sub_q == 2'd2) begin
            sub_d = 2'd0;
            if (col_q == COL_LAST) begin
              col_d = 16'd0;
              if (HAS_PAD) begin
                state_d = S_PAD;
                pad_d   = 2'd0;
              end else if (row_end) begin
                state_d = S_DONE;
              end else begin
                row_d = row_q + 16'd1;
              end
            end else begin
              col_d = col_q + 16'd1;
            end
          end else begin
            sub_d = sub_q + 2'd1;
          end
        end
      end
      S_PAD: begin
        if (hs) begin
          if (pad_end) begin
            pad_d = 2'd0;
            if (row_end) begin
              state_d = S_DONE;
            end else begin
              row_d   = row_q + 16'd1;
              state_d = S_PIXEL;
            end
          end else begin
            pad_d = pad_q + 2'd1;
          end
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        hdr_idx_d = 6'd0;
        row_d     = 16'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      hdr_idx_q <= 6'd0;
      sub_q     <= 2'd0;
      pad_q     <= 2'd0;
      col_q     <= 16'd0;
      row_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      hdr_idx_q <= hdr_idx_d;
      sub_q     <= sub_d;
      pad_q     <= pad_d;
      col_q     <= col_d;
      row_q     <= row_d;
    end
  end

endmodule

// File: tb/tb_bmp_stream_packer.sv
// Directed bench: a 3x2 packer (padded rows) streamed end to end, plus a
// default-size packer whose header size fields are checked.
module tb_bmp_stream_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, hold_empty, rand_ready, rr;
  logic [7:0] mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  logic       in_empty, in_rd, out_valid, out_ready, out_last, busy, done;
  logic [7:0] in_data, out_data;

  assign in_empty  = hold_empty || (rd_ptr == wr_ptr);
  assign in_data   = mem[rd_ptr[5:0]];
  assign out_ready = rand_ready ? rr : 1'b1;

  bmp_stream_packer #(.DATA_WIDTH(8), .IMG_WIDTH(3), .IMG_HEIGHT(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_empty(in_empty), .in_data(in_data),
    .in_rd(in_rd), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  logic       d_start, d_in_rd, d_out_valid, d_out_last, d_busy, d_done;
  logic [7:0] d_out_data;

  bmp_stream_packer u_def (
    .clk(clk), .rst(rst), .start(d_start), .in_empty(1'b1), .in_data(8'h00),
    .in_rd(d_in_rd), .out_valid(d_out_valid), .out_data(d_out_data), .out_ready(1'b1),
    .out_last(d_out_last), .busy(d_busy), .done(d_done)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) if (in_rd) rd_ptr <= rd_ptr + 1;

  always @(posedge clk) begin
    #1;
    rr = 1'($urandom_range(0, 1));
  end

  // Hand-derived header for a 3x2 image: FILE_SZ 78, IMG_SZ 24.
  logic [7:0] hdr [0:53] = '{
    8'h42, 8'h4D, 8'h4E, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00,  8'h36, 8'h00, 8'h00, 8'h00,
    8'h28, 8'h00, 8'h00, 8'h00,  8'h03, 8'h00, 8'h00, 8'h00,
    8'h02, 8'h00, 8'h00, 8'h00,  8'h01, 8'h00, 8'h18, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00,  8'h18, 8'h00, 8'h00, 8'h00,
    8'h13, 8'h0B, 8'h00, 8'h00,  8'h13, 8'h0B, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00,  8'h00, 8'h00, 8'h00, 8'h00
  };

  logic [7:0] exp_b  [0:77];
  logic       exp_rd [0:77];

  task automatic build_exp(input int s0);
    int k;
    for (int i = 0; i < 54; i++) begin
      exp_b[i]  = hdr[i];
      exp_rd[i] = 1'b0;
    end
    k = 54;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) begin
        for (int s = 0; s < 3; s++) begin
          exp_b[k]  = mem[s0 + 3 * r + c];
          exp_rd[k] = (s == 2);
          k++;
        end
      end
      for (int p = 0; p < 3; p++) begin
        exp_b[k]  = 8'h00;
        exp_rd[k] = 1'b0;
        k++;
      end
    end
  endtask

  int         n_got = 0;
  int         base = 0;
  int         n_done = 0;
  logic       prev_stall = 1'b0, prev_lhs = 1'b0, prev_done = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    int idx;
    if (prev_stall) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'(prev_data));
      check("stall_last", 32'(out_last), 32'(prev_last));
    end
    if (in_rd && !(out_valid && out_ready)) check("rd_without_hs", 32'(in_rd), 32'd0);
    if (in_rd && in_empty) check("rd_while_empty", 32'(in_rd), 32'd0);
    if (done) begin
      n_done++;
      check("done_after_last", 32'(prev_lhs), 32'd1);
    end else if (prev_lhs) begin
      check("done_missing", 32'(done), 32'd1);
    end
    if (prev_done) check("busy_after_done", 32'(busy), 32'd0);
    if (out_valid && out_ready) begin
      idx = n_got - base;
      if (idx < 78) begin
        check($sformatf("byte%0d", idx), 32'(out_data), 32'(exp_b[idx]));
        check($sformatf("last%0d", idx), 32'(out_last), 32'(idx == 77));
        check($sformatf("rd%0d", idx), 32'(in_rd), 32'(exp_rd[idx]));
      end else begin
        check("extra_byte", 32'(idx), 32'd77);
      end
      n_got++;
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
    prev_lhs   = out_valid && out_ready && out_last;
    prev_done  = done;
  end

  int         d_n = 0;
  logic [7:0] d_hdr [0:63];

  always @(negedge clk) begin
    if (d_out_valid) begin
      if (d_n < 64) d_hdr[d_n] = d_out_data;
      d_n++;
    end
    if (d_in_rd) check("def_rd_while_empty", 32'(d_in_rd), 32'd0);
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int t;
    t = 0;
    while (n_done == d0 && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    if (n_done == d0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int t;
    t = 0;
    while ((n_got - base) < n && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    if ((n_got - base) < n) check("bytes_timeout", 32'(n_got - base), 32'(n));
  endtask

  initial begin
    int d0;
    rst = 1'b0; start = 1'b0; d_start = 1'b0; hold_empty = 1'b0; rand_ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 6; i++) mem[6 * j + i] = 8'(10 * (i + 1));
    mem[18] = 8'd70;
    mem[19] = 8'd80;
    wr_ptr = 6;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_in_rd", 32'(in_rd), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Default 720x540 header size fields.
    @(posedge clk); #1 d_start = 1'b1;
    @(posedge clk); #1 d_start = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("def_hdr_count", 32'(d_n), 32'd54);
    check("def_magic", {16'd0, d_hdr[1], d_hdr[0]}, 32'h00004D42);
    check("def_file_sz", {d_hdr[5], d_hdr[4], d_hdr[3], d_hdr[2]}, 32'h0011CC76);
    check("def_width", {d_hdr[21], d_hdr[20], d_hdr[19], d_hdr[18]}, 32'h000002D0);
    check("def_height", {d_hdr[25], d_hdr[24], d_hdr[23], d_hdr[22]}, 32'h0000021C);
    check("def_img_sz", {d_hdr[37], d_hdr[36], d_hdr[35], d_hdr[34]}, 32'h0011CC40);
    check("def_pixel_wait", 32'(d_out_valid), 32'd0);

    // Run A: out_ready held high, samples 10..60.
    build_exp(0);
    base = n_got;
    d0 = n_done;
    pulse_start();
    check("a_busy_rise", 32'(busy), 32'd1);
    check("a_valid_rise", 32'(out_valid), 32'd1);
    check("a_first_byte", 32'(out_data), 32'h42);
    wait_done(d0, 300);
    @(posedge clk); #1;
    check("a_byte_count", 32'(n_got - base), 32'd78);
    check("a_pops", 32'(rd_ptr), 32'd6);
    check("a_done_count", 32'(n_done - d0), 32'd1);
    check("a_busy_fall", 32'(busy), 32'd0);

    // Run B: random out_ready, second start in HEADER, underflow mid-pixel.
    wr_ptr = 12;
    build_exp(6);
    base = n_got;
    d0 = n_done;
    rand_ready = 1'b1;
    pulse_start();
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("b_busy_hdr", 32'(busy), 32'd1);
    wait_bytes(56, 600);
    hold_empty = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("b_uflow_valid", 32'(out_valid), 32'd0);
      check("b_uflow_rd", 32'(in_rd), 32'd0);
    end
    check("b_uflow_pops", 32'(rd_ptr), 32'd6);
    @(posedge clk); #1 hold_empty = 1'b0;
    wait_done(d0, 600);
    rand_ready = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("b_byte_count", 32'(n_got - base), 32'd78);
    check("b_pops", 32'(rd_ptr), 32'd12);
    check("b_done_count", 32'(n_done - d0), 32'd1);
    check("b_idle", 32'(busy), 32'd0);

    // Run C: reset during row 0 pixels, then a fresh frame.
    wr_ptr = 20;
    build_exp(12);
    base = n_got;
    pulse_start();
    wait_bytes(60, 300);
    rst = 1'b0;
    #1;
    check("c_rst_valid", 32'(out_valid), 32'd0);
    check("c_rst_data", 32'(out_data), 32'd0);
    check("c_rst_busy", 32'(busy), 32'd0);
    check("c_rst_rd", 32'(in_rd), 32'd0);
    check("c_rst_last", 32'(out_last), 32'd0);
    check("c_rst_pops", 32'(rd_ptr), 32'd14);
    repeat (2) @(posedge clk);
    #1;
    check("c_rst_no_pop", 32'(rd_ptr), 32'd14);
    check("c_def_reset", 32'(d_busy), 32'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("c_no_autostart", 32'(busy), 32'd0);
    build_exp(14);
    base = n_got;
    d0 = n_done;
    pulse_start();
    check("c_first_byte", 32'(out_data), 32'h42);
    wait_done(d0, 300);
    @(posedge clk); #1;
    check("c_byte_count", 32'(n_got - base), 32'd78);
    check("c_pops", 32'(rd_ptr), 32'd20);
    check("c_done_count", 32'(n_done - d0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
